// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds two N-bit operands W bits per clock on valid/ready streams.
// Optional signed-overflow output is enabled by defining CHUNKED_ADDER_OVF_EN.
module chunked_adder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         Ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Co
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CHUNKS = N / W;
    localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [N-1:0] CHUNK_MASK = ~({N{1'b1}} << W);

    generate
        if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_check
            $error("chunked_adder: N must be a non-zero multiple of W with 1 <= W <= N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  s_q, s_d;
    logic          carry_q, carry_d;
    logic          co_q, co_d;
    logic [KW-1:0] k_q, k_d;

    logic [W-1:0]  aChunk;
    logic [W-1:0]  bChunk;
    logic [W:0]    chunkSum;
    logic          lastChunk;

`ifdef CHUNKED_ADDER_OVF_EN
    logic          ovf_q, ovf_d;
    logic          carryIntoTop;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            k_q     <= '0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            k_q     <= k_d;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // The single W-bit adder sees chunk k of the latched operands; subtract was folded into b_q at accept.
    always_comb begin
        aChunk    = W'(a_q >> (k_q * W));
        bChunk    = W'(b_q >> (k_q * W));
        chunkSum  = {1'b0, aChunk} + {1'b0, bChunk} + {{W{1'b0}}, carry_q};
        lastChunk = (k_q == KW'(CHUNKS - 1));
`ifdef CHUNKED_ADDER_OVF_EN
        carryIntoTop = aChunk[W-1] ^ bChunk[W-1] ^ chunkSum[W-1];
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        k_d     = k_q;
`ifdef CHUNKED_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = x;
                    b_d     = sub ? ~y : y;
                    carry_d = sub ? ~Ci : Ci;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = (s_q & ~(CHUNK_MASK << (k_q * W)))
                        | (N'(chunkSum[W-1:0]) << (k_q * W));
                carry_d = chunkSum[W];
                if (lastChunk) begin
                    co_d    = chunkSum[W];
                    k_d     = '0;
                    state_d = DONE;
`ifdef CHUNKED_ADDER_OVF_EN
                    ovf_d   = carryIntoTop ^ chunkSum[W];
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Co        = co_q;
`ifdef CHUNKED_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (N=16, W=4 plus a W=16 instance); scoreboard queue of expected results.
module tb_chunked_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic        sub;
        logic [15:0] expS;
        logic        expCo;
        logic        expOvf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        Ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Co;
    logic        ovf;

    logic        in2Valid;
    logic        in2Ready;
    logic [15:0] x2;
    logic [15:0] y2;
    logic        out2Valid;
    logic        out2Ready;
    logic [15:0] s2;
    logic        co2;
    logic        ovf2;

    int   total = 0;
    int   bad   = 0;
    exp_t expQ[$];

    chunked_adder #(.N(16), .W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .Ci(Ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .S(S), .Co(Co)
`ifdef CHUNKED_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    chunked_adder #(.N(16), .W(16)) dutWide (
        .clk(clk), .rst(rst), .in_valid(in2Valid), .in_ready(in2Ready),
        .x(x2), .y(y2), .Ci(1'b0), .sub(1'b0),
        .out_valid(out2Valid), .out_ready(out2Ready), .S(s2), .Co(co2)
`ifdef CHUNKED_ADDER_OVF_EN
        , .ovf(ovf2)
`endif
    );

`ifndef CHUNKED_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf2 = 1'b0;
`endif

    always #5 clk = ~clk;

    // Whole-word reference: N-bit add of x and effective B with effective carry.
    function automatic exp_t model(input logic [15:0] ax, input logic [15:0] ay,
                                   input logic aci, input logic asub);
        logic [15:0] bEff;
        logic [16:0] r;
        exp_t        e;
        bEff  = asub ? ~ay : ay;
        r     = {1'b0, ax} + {1'b0, bEff} + {16'd0, (asub ? ~aci : aci)};
        e.s   = r[15:0];
        e.co  = r[16];
        e.ovf = (ax[15] == bEff[15]) && (r[15] != ax[15]);
        return e;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] ax, input logic [15:0] ay,
                                 input logic aci, input logic asub, input exp_t e);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        compare("in_ready before accept", 32'(in_ready), 32'd1);
        x        = ax;
        y        = ay;
        Ci       = aci;
        sub      = asub;
        in_valid = 1'b1;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = 16'($urandom);
        y        = 16'($urandom);
    endtask

    task automatic checkOutput(input int expLat);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        compare("out_valid arrives", 32'(out_valid), 32'd1);
        if (expLat >= 0) compare("latency", 32'(n - 1), 32'(expLat));
        if (expQ.size() == 0) begin
            compare("scoreboard not empty", 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            compare("S", 32'(S), 32'(e.s));
            compare("Co", 32'(Co), 32'(e.co));
`ifdef CHUNKED_ADDER_OVF_EN
            compare("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        compare("in_ready after drain", 32'(in_ready), 32'd1);
        compare("out_valid after drain", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        exp_t e;
        int   n;
        int   sent;
        int   got;
        int   lastAcc;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; Ci = 1'b0; sub = 1'b0;
        in2Valid = 1'b0; out2Ready = 1'b0; x2 = '0; y2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compare("reset in_ready", 32'(in_ready), 32'd1);
        compare("reset out_valid", 32'(out_valid), 32'd0);
        compare("reset S", 32'(S), 32'd0);
        compare("reset Co", 32'(Co), 32'd0);

        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            e.s = vecs[i].expS; e.co = vecs[i].expCo; e.ovf = vecs[i].expOvf;
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].ci, vecs[i].sub, e);
            checkOutput(4);
        end

        $display("[TB] random vectors");
        for (int i = 0; i < 6; i++) begin
            logic [15:0] rx, ry;
            logic        rc, rs;
            rx = 16'($urandom); ry = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            applyStimulus(rx, ry, rc, rs, model(rx, ry, rc, rs));
            checkOutput(4);
        end

        $display("[TB] backpressure");
        e = model(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0, e);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x = 16'($urandom); y = 16'($urandom);
            compare("stall out_valid", 32'(out_valid), 32'd1);
            compare("stall in_ready", 32'(in_ready), 32'd0);
            compare("stall S", 32'(S), 32'(e.s));
            compare("stall Co", 32'(Co), 32'(e.co));
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput(-1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare("no ghost accept in_ready", 32'(in_ready), 32'd1);
            compare("no ghost accept out_valid", 32'(out_valid), 32'd0);
        end

        $display("[TB] back-to-back");
        out_ready = 1'b1;
        sent = 0; got = 0; lastAcc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    compare("b2b scoreboard not empty", 32'd0, 32'd1);
                end else begin
                    e = expQ.pop_front();
                    compare("b2b S", 32'(S), 32'(e.s));
                    compare("b2b Co", 32'(Co), 32'(e.co));
                end
                got++;
            end
            if (in_ready && sent < 3) begin
                x = 16'h1000 * 16'(sent + 1) + 16'h0321;
                y = 16'h0F0F;
                Ci = 1'b0; sub = 1'b0;
                in_valid = 1'b1;
                expQ.push_back(model(x, y, 1'b0, 1'b0));
                if (sent > 0) compare("b2b interval", 32'(c - lastAcc), 32'd6);
                lastAcc = c;
                sent++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        compare("b2b results received", 32'(got), 32'd3);

        $display("[TB] reset mid-run");
        @(negedge clk);
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, model(16'h1234, 16'h1111, 1'b0, 1'b0));
        void'(expQ.pop_back());
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compare("abort out_valid", 32'(out_valid), 32'd0);
        compare("abort S", 32'(S), 32'd0);
        compare("abort in_ready", 32'(in_ready), 32'd1);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0});
        checkOutput(4);
        compare("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("[TB] single-chunk instance");
        @(negedge clk);
        compare("wide in_ready", 32'(in2Ready), 32'd1);
        x2 = 16'h7FFF; y2 = 16'h0001; in2Valid = 1'b1;
        @(posedge clk);
        #1 in2Valid = 1'b0;
        n = 0;
        while (!out2Valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        compare("wide latency", 32'(n - 1), 32'd1);
        compare("wide S", 32'(s2), 32'h8000);
        compare("wide Co", 32'(co2), 32'd0);
`ifdef CHUNKED_ADDER_OVF_EN
        compare("wide ovf", 32'(ovf2), 32'd1);
`endif
        out2Ready = 1'b1;
        @(posedge clk);
        #1 out2Ready = 1'b0;
        @(negedge clk);
        compare("wide drain", 32'(in2Ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Multi-cycle, parametrised successor to the combinational ripple-carry adder. It adds or subtracts two N-bit operands W bits per clock, carrying between chunks in a register. Silicon cost is one W-bit full-adder chain instead of N. It sits on valid/ready streams between operand producers and result consumers, for datapaths where area matters more than latency.

## Interface
- N, 16, operand/result width; must be a multiple of W (elaboration error otherwise)
- W, 4, chunk width processed per cycle; 1 ≤ W ≤ N; CHUNKS = N/W
- clk  in  1  clock, rising-edge
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  operand set offered
- in_ready  out  1  block can accept operands
- x  in  N  operand A
- y  in  N  operand B
- Ci  in  1  carry-in (add) / borrow-in (subtract)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- S  out  N  sum/difference
- Co  out  1  carry-out (add) / not-borrow (subtract)
- ovf  out  1  signed overflow; present only with CHUNKED_ADDER_OVF_EN

## Operation
- FSM states and transitions:
  - IDLE → RUN on in_valid & in_ready.
  - RUN → DONE after the CHUNKS-th chunk edge.
  - DONE → IDLE on out_valid & out_ready.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- On accept, x, y, sub and Ci are latched. After this, input pins are don't-care until the next IDLE.
- Effective operand B = sub ? ~y : y. Effective carry-in = sub ? ~Ci : Ci.
  - Add: S = x + y + Ci.
  - Subtract: S = x − y − Ci.
- Result is modulo 2^N. Co is the carry out of bit N−1 (for subtract, 1 = no borrow).
- RUN: a chunk counter k of width clog2(CHUNKS), minimum 1 bit, goes 0..CHUNKS−1, LSB chunk first.
  - Each cycle: S[k*W +: W] ← A_k + B_k + carry_reg, and carry_reg ← chunk carry-out.
  - On the last chunk, Co ← chunk carry-out.
- CHUNKS = 1 (W = N) is legal: a single RUN cycle.
- S and Co are stable throughout DONE. After the output handshake they hold their values until the next accept, but are meaningful only while out_valid = 1.
- No overlap: a new operand is not accepted while RUN or DONE. in_valid in those states is ignored and not queued.
- Reset values: in_ready = 1 from the first cycle after rst is released. out_valid = 0, S = 0, Co = 0, ovf = 0, carry_reg = 0, k = 0, state = IDLE.
- rst asserted in any state, including mid-RUN or in DONE, aborts the operation and discards partial results. rst takes priority over any simultaneous handshake.

## Timing
- Accept at edge t0. Chunk k is computed at edge t0+1+k. DONE is entered, and out_valid = 1, after edge t0+CHUNKS. Latency = CHUNKS cycles.
- in_ready falls after t0.
- Output handshake at edge tD returns the block to IDLE. in_ready = 1 in the cycle after tD.
- Minimum initiation interval = CHUNKS + 2 cycles (accept, CHUNKS run cycles, drain).
- out_ready held low stalls the block in DONE indefinitely with no loss of data.
- Critical path: one W-bit ripple plus the carry_reg mux. The path is independent of N.

## Configuration
- CHUNKED_ADDER_OVF_EN defined:
  - Port ovf exists, computed as (carry into bit N−1) XOR Co on the last chunk.
  - ovf is registered with S and valid in DONE. Reset value 0.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
All cases use N = 16, W = 4 unless stated.
- x = 0x00FF, y = 0x0001, Ci = 0, sub = 0 → S = 0x0100, Co = 0. out_valid rises exactly 4 cycles after the accept edge.
- x = 0xFFFF, y = 0x0000, Ci = 1, sub = 0 → S = 0x0000, Co = 1. This exercises the carry rippling through all 4 chunks.
- Subtract, x = 0x0005, y = 0x0007, sub = 1:
  - Ci = 0 → S = 0xFFFE, Co = 0.
  - Ci = 1 → S = 0xFFFD, Co = 0.
  - x = 0x0007, y = 0x0005, Ci = 0 → S = 0x0002, Co = 1.
- Backpressure: out_ready = 0 for 5 cycles after DONE, while in_valid is pulsed with new operands.
  - S, Co and out_valid stay constant and in_ready stays 0.
  - The new operands are never accepted.
  - Afterwards, back-to-back operations achieve the 6-cycle interval.
- rst pulsed for 1 cycle after the 2nd chunk of x = 0x1234 + y = 0x1111:
  - The next cycle shows out_valid = 0, S = 0, in_ready = 1.
  - A following 0x0001 + 0x0001 gives S = 0x0002.
- With CHUNKED_ADDER_OVF_EN, x = 0x7FFF + y = 0x0001 → S = 0x8000, ovf = 1, Co = 0.
  - Repeat the same case with W = 16 (CHUNKS = 1): latency 1 cycle, same results.
